// File: rtl/ddr_phy_train_pkg.sv
// ddr_phy_train_pkg: shared state encoding and result codes for the DDR4 PHY training controllers
//   no ports; provides train_state_t, FAIL_* codes, DIR_INC and is_busy()
package ddr_phy_train_pkg;
  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    DECIDE,
    STEP,
    DONE,
    FAIL
  } train_state_t;
  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_NO_EDGE = 2'b01;
  localparam logic [1:0] FAIL_OOR     = 2'b10;
  localparam logic [1:0] FAIL_ABORT   = 2'b11;
  localparam logic       DIR_INC      = 1'b0;
  function automatic logic is_busy(train_state_t s);
    return !(s inside {IDLE, DONE, FAIL});
  endfunction
endpackage

// File: rtl/dqsw_sample_accum.sv
// dqsw_sample_accum: per-tap feedback accumulator with strict-majority vote and eye-monitor flag capture
//   clk, rst_n      : fabric clock, async active-low reset
//   clr             : zero the accumulator, flag and sample counter
//   en              : accumulate this cycle (SAMPLE state)
//   rx_data         : 2-bit write-leveling feedback
//   eye_early/late  : eye-monitor flags, captured only while en
//   vote            : ones count strictly above SAMPLE_COUNT (tie reads as 0)
//   em_flag         : any eye-monitor flag seen while en
//   sample_done     : high in the last enabled sample cycle
module dqsw_sample_accum
  import ddr_phy_train_pkg::*;
#(
  parameter int SAMPLE_COUNT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] rx_data,
  input  logic       eye_early,
  input  logic       eye_late,
  output logic       vote,
  output logic       em_flag,
  output logic       sample_done
);
  localparam int OW = $clog2(2 * SAMPLE_COUNT + 1);
  localparam int CW = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic [CW-1:0] smp_cnt_q, smp_cnt_d;
  logic          em_flag_q, em_flag_d;
  assign sample_done = en && (smp_cnt_q == CW'(SAMPLE_COUNT - 1));
  assign vote        = ones_cnt_q > OW'(SAMPLE_COUNT);
  assign em_flag     = em_flag_q;
  always_comb begin
    ones_cnt_d = clr ? '0 : en ? ones_cnt_q + OW'(rx_data[0]) + OW'(rx_data[1]) : ones_cnt_q;
    em_flag_d  = clr ? 1'b0 : em_flag_q | (en & (eye_early | eye_late));
    smp_cnt_d  = (clr || sample_done) ? '0 : en ? smp_cnt_q + CW'(1) : smp_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ones_cnt_q <= '0;
      em_flag_q  <= 1'b0;
      smp_cnt_q  <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
      em_flag_q  <= em_flag_d;
      smp_cnt_q  <= smp_cnt_d;
    end
endmodule

// File: rtl/dqsw_tap_trainer.sv
// dqsw_tap_trainer: per-lane DQSW write-leveling controller sweeping the IOD delay line for the 0->1 feedback edge
//   FAB_CLK, ARST_N            : fabric clock, async active-low reset
//   start, abort               : begin training (pulse) / terminate training (level)
//   RX_DATA, EYE_MONITOR_*     : IOD feedback and eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE    : IOD delay-line limit flag, honoured only while settling
//   DELAY_LINE_LOAD/MOVE/DIR   : IOD delay-line controls (registered one-cycle strobes)
//   EYE_MONITOR_CLEAR_FLAGS    : IOD eye-monitor clear strobe
//   busy, done, fail, fail_code: training status
//   tap_count, edge_tap        : current tap offset and tap of the found edge
//   edge_unstable              : eye-monitor flag seen while sampling the edge tap
module dqsw_tap_trainer
  import ddr_phy_train_pkg::*;
#(
  parameter int MAX_TAPS      = 128,
  parameter int TAP_W         = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 16
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       RX_DATA,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [TAP_W-1:0] tap_count,
  output logic [TAP_W-1:0] edge_tap,
  output logic             edge_unstable
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  train_state_t     state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d, edge_tap_q, edge_tap_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic             seen_zero_q, seen_zero_d, edge_unstable_q, edge_unstable_d;
  logic             load_q, load_d, move_q, move_d, clr_flags_q, clr_flags_d;
  logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic             vote, em_flag, sample_done;
  dqsw_sample_accum #(.SAMPLE_COUNT(SAMPLE_COUNT)) u_accum (
    .clk        (FAB_CLK),
    .rst_n      (ARST_N),
    .clr        (state_q == CLEAR),
    .en         (state_q == SAMPLE),
    .rx_data    (RX_DATA),
    .eye_early  (EYE_MONITOR_EARLY),
    .eye_late   (EYE_MONITOR_LATE),
    .vote       (vote),
    .em_flag    (em_flag),
    .sample_done(sample_done)
  );
  always_comb begin
    state_d         = state_q;
    tap_d           = tap_q;
    settle_d        = settle_q;
    seen_zero_d     = seen_zero_q;
    edge_tap_d      = edge_tap_q;
    edge_unstable_d = edge_unstable_q;
    fail_code_d     = fail_code_q;
    // abort outranks every in-state decision, including out-of-range and DECIDE exits
    if (abort && busy_q) begin
      state_d     = FAIL;
      fail_code_d = FAIL_ABORT;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL:
          if (start && !abort) begin
            state_d         = LOAD;
            fail_code_d     = FAIL_NONE;
            edge_tap_d      = '0;
            edge_unstable_d = 1'b0;
          end
        LOAD: begin
          state_d     = CLEAR;
          tap_d       = '0;
          seen_zero_d = 1'b0;
        end
        CLEAR: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE:
          if (DELAY_LINE_OUT_OF_RANGE) begin
            state_d     = FAIL;
            fail_code_d = FAIL_OOR;
          end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d = SAMPLE;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        SAMPLE:
          if (sample_done) state_d = DECIDE;
        DECIDE: begin
          // a 1 only counts as the edge once a 0 has been seen earlier in the sweep
          seen_zero_d = seen_zero_q | ~vote;
          if (vote && seen_zero_q) begin
            state_d         = DONE;
            edge_tap_d      = tap_q;
            edge_unstable_d = em_flag;
          end else if (tap_q == TAP_W'(MAX_TAPS - 1)) begin
            state_d     = FAIL;
            fail_code_d = FAIL_NO_EDGE;
          end else begin
            state_d = STEP;
          end
        end
        STEP: begin
          state_d = CLEAR;
          tap_d   = tap_q + TAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    // strobes and status are decoded from the next state so they are flop outputs
    load_d      = state_d == LOAD;
    move_d      = state_d == STEP;
    clr_flags_d = state_d == CLEAR;
    busy_d      = is_busy(state_d);
    done_d      = state_d == DONE;
    fail_d      = state_d == FAIL;
  end
  always_ff @(posedge FAB_CLK or negedge ARST_N)
    if (!ARST_N) begin
      state_q         <= IDLE;
      tap_q           <= '0;
      settle_q        <= '0;
      seen_zero_q     <= 1'b0;
      edge_tap_q      <= '0;
      edge_unstable_q <= 1'b0;
      fail_code_q     <= FAIL_NONE;
      load_q          <= 1'b0;
      move_q          <= 1'b0;
      clr_flags_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      tap_q           <= tap_d;
      settle_q        <= settle_d;
      seen_zero_q     <= seen_zero_d;
      edge_tap_q      <= edge_tap_d;
      edge_unstable_q <= edge_unstable_d;
      fail_code_q     <= fail_code_d;
      load_q          <= load_d;
      move_q          <= move_d;
      clr_flags_q     <= clr_flags_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      fail_q          <= fail_d;
    end
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = DIR_INC;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_flags_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign fail                    = fail_q;
  assign fail_code               = fail_code_q;
  assign tap_count               = tap_q;
  assign edge_tap                = edge_tap_q;
  assign edge_unstable           = edge_unstable_q;
endmodule
